// File: rtl/vga_pkg.sv
// Shared VGA-path definitions.
// Provides the background ROM geometry used as parameter defaults by the
// ROM arbiter, and the {valid, is_aux} tag carried alongside each ROM read.
package vga_pkg;

  localparam int BG_ROM_ADDR_W = 17;  // {vcount[10:3], hcount[10:2]}
  localparam int BG_ROM_DATA_W = 12;  // RGB444

  // Tag travelling with each ROM read so the returning word can be steered
  // to the video path or to the aux requester.
  typedef struct packed {
    logic vld;
    logic is_aux;
  } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// ROM read tag pipeline.
// A DEPTH-deep shift register of {valid, is_aux} tags that tracks each
// read issued to the ROM until its data appears on the ROM output.
// Ports:
//   clk, rst             clock, synchronous active-high clear
//   in_vld, in_is_aux    tag for the read issued this cycle
//   out_vld, out_is_aux  tag for the ROM word presented this cycle
module rom_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_is_aux,
  output logic out_vld,
  output logic out_is_aux
);

  rom_tag_t tag_p [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_p[k] <= '0;
      end
    end else begin
      tag_p[0] <= '{vld: in_vld, is_aux: in_is_aux};
      for (int k = 1; k < DEPTH; k++) begin
        tag_p[k] <= tag_p[k-1];
      end
    end
  end

  // ---- last stage: aligned with ROM output ----
  assign out_vld    = tag_p[DEPTH-1].vld;
  assign out_is_aux = tag_p[DEPTH-1].is_aux;

endmodule

// File: rtl/bg_rom_arbiter.sv
// Background ROM read-port arbiter.
// Shares the single background ROM port between the real-time video path
// and an auxiliary requester (crosshair hit detection). Video owns the port
// during visible pixels; aux reads are granted only in blanking through a
// req/ack handshake, and returning words are steered by a tag pipeline.
// ROM_LATENCY must lie in 1..4.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   vid_active, vid_addr  video request (visible pixel flag + address)
//   vid_rgb               video pixel, ROM_LATENCY cycles after vid_addr
//   aux_req, aux_addr     aux request level + address, held until aux_ack
//   aux_ack               one-cycle grant
//   aux_valid, aux_data   aux return pulse + held data word
//   rom_addr, rom_en      to ROM
//   rom_dout              from ROM
module bg_rom_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH  = BG_ROM_ADDR_W,
  parameter int DATA_WIDTH  = BG_ROM_DATA_W,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vid_active,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_rgb,
  input  logic                  aux_req,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  output logic                  aux_ack,
  output logic                  aux_valid,
  output logic [DATA_WIDTH-1:0] aux_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  typedef enum logic {
    IDLE,
    AUX_WAIT
  } arb_state_t;

  arb_state_t state, state_next;
  logic       grant;
  logic       ret_vld, ret_is_aux;
  logic       ret_vid, ret_aux;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant is also masked by rst so nothing is issued while in reset.
  // AUX_WAIT holds off further grants until the outstanding word returns,
  // which keeps exactly one aux read in flight.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    unique case (state)
      IDLE: begin
        if (aux_req && !vid_active && !rst) begin
          grant      = 1'b1;
          state_next = AUX_WAIT;
        end
      end
      AUX_WAIT: begin
        if (aux_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- stage 0: ROM address/enable issue ----
  always_comb begin
    aux_ack  = grant;
    rom_addr = grant ? aux_addr : vid_addr;
    rom_en   = grant || (vid_active && !rst);
  end

  rom_tag_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (rom_en),
    .in_is_aux  (grant),
    .out_vld    (ret_vld),
    .out_is_aux (ret_is_aux)
  );

  // ---- stage ROM_LATENCY: ROM word returns, steered by tag ----
  assign ret_vid = ret_vld && !ret_is_aux;
  assign ret_aux = ret_vld &&  ret_is_aux;

  // Blanking and aux-return slots show black on the video path.
  assign vid_rgb = ret_vid ? rom_dout : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      aux_valid <= 1'b0;
      aux_data  <= '0;
    end else begin
      aux_valid <= ret_aux;
      if (ret_aux) aux_data <= rom_dout;
    end
  end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Testbench for bg_rom_arbiter: table-driven vectors, hand sequences for the
// long-wait and reset-in-flight corners, then randomized traffic checked
// against a cycle-indexed schedule model of expected returns.
module tb_bg_rom_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 12;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst, vid_active, aux_req;
  logic [AW-1:0] vid_addr, aux_addr, rom_addr;
  logic [DW-1:0] vid_rgb, aux_data, rom_dout;
  logic          aux_ack, aux_valid, rom_en;

  always #5 clk = ~clk;

  bg_rom_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .ROM_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vid_active (vid_active),
    .vid_addr   (vid_addr),
    .vid_rgb    (vid_rgb),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_ack    (aux_ack),
    .aux_valid  (aux_valid),
    .aux_data   (aux_data),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_dout   (rom_dout)
  );

  // ROM model: content is addr[11:0], LAT cycles read latency, output holds
  // when not enabled.
  logic [DW-1:0] rom_q [LAT];
  always @(posedge clk) begin
    if (rom_en) rom_q[0] <= rom_addr[DW-1:0];
    for (int k = 1; k < LAT; k++) rom_q[k] <= rom_q[k-1];
  end
  assign rom_dout = rom_q[LAT-1];

  typedef struct {
    logic          rst;
    logic          va;
    logic [AW-1:0] vaddr;
    logic          req;
    logic [AW-1:0] aaddr;
    logic          e_ack;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic          c_reg;
    logic [DW-1:0] e_rgb;
    logic          e_av;
    logic [DW-1:0] e_ad;
  } vec_t;

  function automatic vec_t mk(logic r, logic va, logic [AW-1:0] vaddr,
                              logic req, logic [AW-1:0] aaddr,
                              logic ack, logic en, logic [AW-1:0] addr,
                              logic creg, logic [DW-1:0] rgb, logic av,
                              logic [DW-1:0] ad);
    vec_t v;
    v.rst = r; v.va = va; v.vaddr = vaddr; v.req = req; v.aaddr = aaddr;
    v.e_ack = ack; v.e_en = en; v.e_addr = addr; v.c_reg = creg;
    v.e_rgb = rgb; v.e_av = av; v.e_ad = ad;
    return v;
  endfunction

  int checks   = 0;
  int failures = 0;

  // Reference model: expected outputs indexed by absolute cycle number.
  int            cyc = 0;
  bit            busy = 0;
  bit            armed = 0;
  logic [DW-1:0] last_aux = '0;
  logic [DW-1:0] vid_sched [int];
  logic [DW-1:0] aux_sched [int];
  logic          last_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic          e_ack, e_en, e_av;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rgb, e_ad;
    int            dk [$];
    e_ack  = !rst && !busy && aux_req && !vid_active;
    e_en   = !rst && (e_ack || vid_active);
    e_addr = e_ack ? aux_addr : vid_addr;
    e_rgb  = vid_sched.exists(cyc) ? vid_sched[cyc] : '0;
    e_av   = aux_sched.exists(cyc);
    e_ad   = e_av ? aux_sched[cyc] : last_aux;
    chk("mdl_ack", aux_ack, e_ack);
    chk("mdl_en", rom_en, e_en);
    if (e_en) chk("mdl_addr", rom_addr, e_addr);
    if (armed) begin
      chk("mdl_rgb", vid_rgb, e_rgb);
      chk("mdl_av", aux_valid, e_av);
      chk("mdl_ad", aux_data, e_ad);
    end
    if (e_av) begin
      last_aux = e_ad;
      busy = 0;
    end
    if (e_ack) begin
      busy = 1;
      aux_sched[cyc+LAT+1] = aux_addr[DW-1:0];
    end else if (e_en) begin
      vid_sched[cyc+LAT] = vid_addr[DW-1:0];
    end
    if (rst) begin
      foreach (vid_sched[k]) if (k > cyc) dk.push_back(k);
      foreach (dk[i]) vid_sched.delete(dk[i]);
      dk.delete();
      foreach (aux_sched[k]) if (k > cyc) dk.push_back(k);
      foreach (dk[i]) aux_sched.delete(dk[i]);
      busy = 0;
      last_aux = '0;
      armed = 1;
    end
    if (vid_sched.exists(cyc)) vid_sched.delete(cyc);
    if (aux_sched.exists(cyc)) aux_sched.delete(cyc);
    cyc++;
  endtask

  task automatic run_cycle(input vec_t v, input bit hand);
    rst        = v.rst;
    vid_active = v.va;
    vid_addr   = v.vaddr;
    aux_req    = v.req;
    aux_addr   = v.aaddr;
    @(negedge clk);
    last_ack = aux_ack;
    if (hand) begin
      chk("tab_ack", aux_ack, v.e_ack);
      chk("tab_en", rom_en, v.e_en);
      if (v.e_en) chk("tab_addr", rom_addr, v.e_addr);
      if (v.c_reg) begin
        chk("tab_rgb", vid_rgb, v.e_rgb);
        chk("tab_av", aux_valid, v.e_av);
        chk("tab_ad", aux_data, v.e_ad);
      end
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  vec_t tab [24];

  initial begin
    vec_t v;
    bit            pend;
    bit            va;
    int            run;
    logic [AW-1:0] paddr;

    // rst, va, vaddr, req, aaddr | ack, en, addr, c_reg, rgb, av, ad
    tab[0]  = mk(1, 0, 0,        1, 17'h1ABCD, 0, 0, 0,         0, 0,      0, 0);
    tab[1]  = mk(1, 0, 0,        1, 17'h1ABCD, 0, 0, 0,         1, 0,      0, 0);
    tab[2]  = mk(1, 0, 0,        1, 17'h1ABCD, 0, 0, 0,         1, 0,      0, 0);
    tab[3]  = mk(0, 1, 17'h123,  0, 0,         0, 1, 17'h123,   1, 0,      0, 0);
    tab[4]  = mk(0, 1, 17'h124,  0, 0,         0, 1, 17'h124,   1, 12'h123, 0, 0);
    tab[5]  = mk(0, 0, 0,        1, 17'h1ABCD, 1, 1, 17'h1ABCD, 1, 12'h124, 0, 0);
    tab[6]  = mk(0, 0, 0,        0, 0,         0, 0, 0,         1, 0,      0, 0);
    tab[7]  = mk(0, 0, 0,        0, 0,         0, 0, 0,         1, 0,      1, 12'hBCD);
    tab[8]  = mk(0, 1, 17'h200,  0, 0,         0, 1, 17'h200,   1, 0,      0, 12'hBCD);
    tab[9]  = mk(0, 1, 17'h201,  0, 0,         0, 1, 17'h201,   1, 12'h200, 0, 12'hBCD);
    tab[10] = mk(0, 0, 0,        1, 17'h0F00F, 1, 1, 17'h0F00F, 1, 12'h201, 0, 12'hBCD);
    tab[11] = mk(0, 1, 17'h333,  0, 0,         0, 1, 17'h333,   1, 0,      0, 12'hBCD);
    tab[12] = mk(0, 1, 17'h334,  0, 0,         0, 1, 17'h334,   1, 12'h333, 1, 12'h00F);
    tab[13] = mk(0, 1, 17'h335,  0, 0,         0, 1, 17'h335,   1, 12'h334, 0, 12'h00F);
    tab[14] = mk(0, 0, 0,        1, 17'h00AAA, 1, 1, 17'h00AAA, 1, 12'h335, 0, 12'h00F);
    tab[15] = mk(0, 0, 0,        1, 17'h00BBB, 0, 0, 0,         1, 0,      0, 12'h00F);
    tab[16] = mk(0, 0, 0,        1, 17'h00BBB, 0, 0, 0,         1, 0,      1, 12'hAAA);
    tab[17] = mk(0, 0, 0,        1, 17'h00BBB, 1, 1, 17'h00BBB, 1, 0,      0, 12'hAAA);
    tab[18] = mk(0, 0, 0,        0, 0,         0, 0, 0,         1, 0,      0, 12'hAAA);
    tab[19] = mk(0, 0, 0,        0, 0,         0, 0, 0,         1, 0,      1, 12'hBBB);
    tab[20] = mk(0, 1, 17'h010,  1, 17'h01111, 0, 1, 17'h010,   1, 0,      0, 12'hBBB);
    tab[21] = mk(0, 1, 17'h011,  0, 0,         0, 1, 17'h011,   1, 12'h010, 0, 12'hBBB);
    tab[22] = mk(0, 0, 0,        0, 0,         0, 0, 0,         1, 12'h011, 0, 12'hBBB);
    tab[23] = mk(0, 0, 0,        0, 0,         0, 0, 0,         1, 0,      0, 12'hBBB);

    for (int i = 0; i < 24; i++) run_cycle(tab[i], 1);

    // Aux request held through 50 active cycles, then granted on first blank.
    for (int i = 0; i < 50; i++) begin
      v = mk(0, 1, AW'(17'h00400 + i), 1, 17'h05555, 0, 1, AW'(17'h00400 + i), 0, 0, 0, 0);
      run_cycle(v, 1);
    end
    run_cycle(mk(0, 0, 0, 1, 17'h05555, 1, 1, 17'h05555, 0, 0, 0, 0), 1);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'hBBB), 1);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 12'h555), 1);

    // Reset the cycle after a grant: the in-flight return must vanish.
    run_cycle(mk(0, 0, 0, 1, 17'h1F0F0, 1, 1, 17'h1F0F0, 1, 0, 0, 12'h555), 1);
    run_cycle(mk(1, 0, 0, 0, 0,         0, 0, 0,         1, 0, 0, 12'h555), 1);
    run_cycle(mk(0, 0, 0, 0, 0,         0, 0, 0,         1, 0, 0, 0), 1);
    run_cycle(mk(0, 0, 0, 0, 0,         0, 0, 0,         1, 0, 0, 0), 1);
    run_cycle(mk(0, 0, 0, 1, 17'h00777, 1, 1, 17'h00777, 1, 0, 0, 0), 1);
    run_cycle(mk(0, 0, 0, 0, 0,         0, 0, 0,         1, 0, 0, 0), 1);
    run_cycle(mk(0, 0, 0, 0, 0,         0, 0, 0,         1, 0, 1, 12'h777), 1);

    // Randomized traffic: alternating active/blank runs, a requester that
    // honours the handshake (occasionally abandoning a request), rare resets.
    pend  = 0;
    va    = 0;
    run   = 0;
    paddr = '0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        va  = !va;
        run = va ? int'($urandom_range(5, 40)) : int'($urandom_range(1, 12));
      end
      run--;
      if (pend && last_ack) pend = 0;
      else if (pend && $urandom_range(0, 39) == 0) pend = 0;
      else if (!pend && $urandom_range(0, 3) == 0) begin
        pend  = 1;
        paddr = AW'($urandom);
      end
      v = mk(($urandom_range(0, 299) == 0), va, AW'($urandom), pend, paddr,
             0, 0, 0, 0, 0, 0, 0);
      run_cycle(v, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_rom_arbiter.md
Name: bg_rom_arbiter

Overview:
Shares the single read port of the background image ROM between two requesters. The first is the real-time VGA background path (vcount/hcount-derived address). The second is an auxiliary requester, the hit-detection logic that samples the background colour under the crosshair.
- Video always owns the port during active pixels.
- Aux reads are granted only in blanking, through a req/ack handshake and a tagged return pipeline.
- Sits between the background-draw stage, the game/hit logic and the ROM instance.

Parameters:
ADDR_WIDTH, 17, ROM address width.
DATA_WIDTH, 12, ROM word width (RGB444).
ROM_LATENCY, 1, cycles from rom_addr/rom_en to valid rom_dout (legal range 1..4).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
vid_active  in  1  1 = vid_addr is for a visible pixel (not hblnk/vblnk), aligned with vid_addr
vid_addr  in  ADDR_WIDTH  video ROM address ({vcount[10:3], hcount[10:2]})
vid_rgb  out  DATA_WIDTH  video pixel data, ROM_LATENCY cycles after vid_addr
aux_req  in  1  aux read request; level, held with aux_addr until aux_ack
aux_addr  in  ADDR_WIDTH  aux read address
aux_ack  out  1  one-cycle grant; aux_addr captured by ROM this cycle
aux_valid  out  1  one-cycle pulse, aux_data valid
aux_data  out  DATA_WIDTH  returned aux word, held until next aux_valid
rom_addr  out  ADDR_WIDTH  to ROM addrA
rom_en  out  1  to ROM en
rom_dout  in  DATA_WIDTH  from ROM dout

Behaviour:
- FSM states: IDLE, AUX_WAIT.
- Grant condition: state==IDLE && aux_req && !vid_active.
- IDLE → AUX_WAIT on grant.
- AUX_WAIT → IDLE on the cycle aux_valid is asserted.
- Port mux (combinational):
  - grant: rom_addr=aux_addr, rom_en=1, aux_ack=1.
  - else: rom_addr=vid_addr, rom_en=vid_active, aux_ack=0.
- Tag pipeline: ROM_LATENCY stages of {valid, is_aux}. Stage 0 loads {rom_en, grant}; stage k loads stage k-1.
- Video return: vid_rgb = rom_dout when last stage is {1,0}, else 0. Blanking and aux-return slots therefore output black. No added latency beyond ROM_LATENCY.
- Aux return: when last stage is {1,1}, aux_data <= rom_dout and aux_valid <= 1 (registered). aux_valid rises exactly ROM_LATENCY+1 cycles after aux_ack.
- Only one aux read is outstanding at a time. Minimum aux request spacing is ROM_LATENCY+2 cycles (ack to next ack).
- Video priority: an aux_req during active video waits with no timeout. It is granted on the first cycle with vid_active=0. The requester must keep aux_req and aux_addr stable until aux_ack.
- vid_active rising while in AUX_WAIT: the in-flight aux read completes normally, because the tags keep the two streams separate.
- aux_req dropped before ack: no grant, no side effects.
- Reset values: state IDLE, tag pipeline all 0, aux_valid 0, aux_data 0. Hence vid_rgb 0, aux_ack 0, rom_en 0 while rst=1.
- Reset mid-operation: the pending aux return is discarded and no aux_valid is issued after reset.

Decomposition:
- vga_pkg gains BG_ROM_ADDR_W=17 and BG_ROM_DATA_W=12, used as the parameter defaults.
- A local typedef enum {IDLE, AUX_WAIT} arb_state_t stays inside the module.
- One natural sub-module: rom_tag_pipe, a parameterised ROM_LATENCY-deep shift register of {valid, is_aux} with synchronous clear.
- The ROM instance (template_rom) stays outside, instantiated by the parent.

Test Plan:
1. Reset: rst high for 3 cycles with aux_req=1 → aux_ack, aux_valid, rom_en, vid_rgb all 0.
2. Video pass-through (ROM model dout=addr[11:0]): vid_active=1, vid_addr=0x00123 → rom_en=1, vid_rgb=12'h123 one cycle later; aux_ack stays 0.
3. Aux in blanking: vid_active=0, aux_req=1, aux_addr=0x1ABCD at cycle N → aux_ack=1 at N, rom_addr=0x1ABCD, aux_valid=1 with aux_data=12'hBCD at N+2, vid_rgb=0 at N+1.
4. Aux during active video: aux_req=1 while vid_active=1 for 50 cycles → aux_ack=0 throughout. On the first vid_active=0 cycle, aux_ack=1.
5. Boundary: grant on the last blank cycle, vid_active=1 the next cycle → aux_valid and correct aux_data at ack+2; video pixels resume with correct data and no corruption.
6. Reset in AUX_WAIT: rst pulsed the cycle after aux_ack → no aux_valid follows, aux_data=0, FSM accepts a new request in the next blanking.
